// File: rtl/waveform_mode_sequencer.sv
// Break-before-make sequencer for the waveform output stage: applies requested or auto-scanned
// output modes, always passing through an all-off drain of DEAD_CYCLES between two modes.
module waveform_mode_sequencer #(
  parameter int DEAD_CYCLES  = 4,
  parameter int DWELL_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_mode,
  output logic       o_req_ready,
  input  logic       i_auto_en,
  output logic [2:0] o_mode_sel,
  output logic [3:0] o_out_en,
  output logic       o_busy,
  output logic       o_switch_done,
  output logic       o_invalid_req
);

  typedef enum logic {ST_STEADY, ST_DRAIN} state_t;

  localparam logic [2:0] MODE_OFF  = 3'b000;
  localparam logic [2:0] MODE_TRI  = 3'b100;
  localparam logic [2:0] MODE_R2R  = 3'b010;
  localparam logic [2:0] MODE_BUZZ = 3'b110;
  localparam logic [2:0] MODE_SAW  = 3'b001;

  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  function automatic logic f_legal(input logic [2:0] m);
    return (m == MODE_OFF) || (m == MODE_TRI) || (m == MODE_R2R) ||
           (m == MODE_BUZZ) || (m == MODE_SAW);
  endfunction

  // Enable bus order is {saw, buzz, r2r, tri}; off and illegal codes decode to all-off.
  function automatic logic [3:0] f_decode(input logic [2:0] m);
    case (m)
      MODE_TRI:  return 4'b0001;
      MODE_R2R:  return 4'b0010;
      MODE_BUZZ: return 4'b0100;
      MODE_SAW:  return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] f_next(input logic [2:0] m);
    case (m)
      MODE_TRI:  return MODE_R2R;
      MODE_R2R:  return MODE_BUZZ;
      MODE_BUZZ: return MODE_SAW;
      default:   return MODE_TRI;
    endcase
  endfunction

  state_t           r_state;
  logic [2:0]       r_cur_mode;
  logic [2:0]       r_pending;
  logic [CNT_W-1:0] r_dead_cnt;
  logic [CNT_W-1:0] r_dwell_cnt;
  logic             r_req_ready;
  logic [2:0]       r_mode_sel;
  logic [3:0]       r_out_en;
  logic             r_busy;
  logic             r_switch_done;
  logic             r_invalid_req;

  logic       w_accept;
  logic       w_req_legal;
  logic       w_dwell_expire;
  logic       w_start_drain;
  logic [2:0] w_target;

  // r_req_ready is high only in STEADY, so an accept implies STEADY.
  assign w_accept       = i_req_valid && r_req_ready;
  assign w_req_legal    = f_legal(i_req_mode);
  assign w_dwell_expire = i_auto_en && (r_dwell_cnt == DWELL_LAST);
  // A request in the same cycle as dwell expiry wins over the auto step.
  assign w_start_drain  = (r_state == ST_STEADY) &&
                          (w_accept ? (w_req_legal && (i_req_mode != r_cur_mode))
                                    : w_dwell_expire);
  assign w_target       = w_accept ? i_req_mode : f_next(r_cur_mode);

  // NOTE: state is updated only with non-blocking assignments so every register samples
  // pre-edge values; reset is asynchronous so outputs go safe without a running clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_STEADY;
      r_cur_mode    <= MODE_OFF;
      r_pending     <= MODE_OFF;
      r_dead_cnt    <= '0;
      r_dwell_cnt   <= '0;
      r_req_ready   <= 1'b1;
      r_mode_sel    <= MODE_OFF;
      r_out_en      <= 4'b0000;
      r_busy        <= 1'b0;
      r_switch_done <= 1'b0;
      r_invalid_req <= 1'b0;
    end else begin
      r_switch_done <= 1'b0;
      r_invalid_req <= 1'b0;
      case (r_state)
        ST_STEADY: begin
          if (w_start_drain) begin
            r_state     <= ST_DRAIN;
            r_pending   <= w_target;
            r_mode_sel  <= MODE_OFF;
            r_out_en    <= 4'b0000;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
            r_dead_cnt  <= '0;
            r_dwell_cnt <= '0;
          end else if (w_accept) begin
            r_dwell_cnt <= '0;
            if (!w_req_legal) r_invalid_req <= 1'b1;
            else              r_switch_done <= 1'b1;
          end else if (!i_auto_en) begin
            r_dwell_cnt <= '0;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_dead_cnt == DEAD_LAST) begin
            r_state       <= ST_STEADY;
            r_cur_mode    <= r_pending;
            r_mode_sel    <= r_pending;
            r_out_en      <= f_decode(r_pending);
            r_busy        <= 1'b0;
            r_req_ready   <= 1'b1;
            r_switch_done <= 1'b1;
            r_dead_cnt    <= '0;
            r_dwell_cnt   <= '0;
          end else begin
            r_dead_cnt <= r_dead_cnt + 1'b1;
          end
        end
        default: r_state <= ST_STEADY;
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_mode_sel    = r_mode_sel;
  assign o_out_en      = r_out_en;
  assign o_busy        = r_busy;
  assign o_switch_done = r_switch_done;
  assign o_invalid_req = r_invalid_req;

endmodule

// File: tb/tb_waveform_mode_sequencer.sv
// Scoreboard bench for waveform_mode_sequencer: stimulus pushes expected switch/invalid events,
// a negedge monitor pops and compares them, plus directed checks on reset and drain behaviour.
module tb_waveform_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_req_valid = 1'b0;
  logic [2:0] i_req_mode = 3'b000;
  logic       o_req_ready;
  logic       i_auto_en = 1'b0;
  logic [2:0] o_mode_sel;
  logic [3:0] o_out_en;
  logic       o_busy;
  logic       o_switch_done;
  logic       o_invalid_req;

  waveform_mode_sequencer #(.DEAD_CYCLES(4), .DWELL_CYCLES(16), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_req_mode   (i_req_mode),
    .o_req_ready  (o_req_ready),
    .i_auto_en    (i_auto_en),
    .o_mode_sel   (o_mode_sel),
    .o_out_en     (o_out_en),
    .o_busy       (o_busy),
    .o_switch_done(o_switch_done),
    .o_invalid_req(o_invalid_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_inv;
    logic [2:0] mode;
    logic [3:0] en;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_inv, input logic [2:0] m, input logic [3:0] en, input int c);
    exp_t e;
    e.is_inv = is_inv;
    e.mode   = m;
    e.en     = en;
    e.cyc    = c;
    sb.push_back(e);
  endtask

  // Monitor: safety invariants every cycle, scoreboard compare on every output event.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_en_safe", ($onehot0(o_out_en) && !(o_busy && o_out_en != 4'b0000)), 1);
      if (o_switch_done || o_invalid_req) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {o_switch_done, o_invalid_req}, 2'b00);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ev_kind", {o_switch_done, o_invalid_req}, e.is_inv ? 2'b01 : 2'b10);
          check("ev_mode_sel", o_mode_sel, e.mode);
          check("ev_out_en", o_out_en, e.en);
          check("ev_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; issues one request and returns after the accepting edge.
  task automatic do_req(input logic [2:0] m, input bit is_inv, input logic [2:0] em,
                        input logic [3:0] een, input int lat, output int t);
    int b = 0;
    while (!o_req_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("req_ready_wait", (b < 100), 1);
    i_req_valid = 1'b1;
    i_req_mode  = m;
    t           = cyc;
    if (lat > 0) push(is_inv, em, een, t + lat);
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (sb.size() != 0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    check("idle_wait", (b < 300), 1);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, k, s, b;

    // Reset values while held in reset and after release.
    repeat (3) @(negedge clk);
    check("rst_req_ready", o_req_ready, 1);
    check("rst_mode_sel", o_mode_sel, 3'b000);
    check("rst_out_en", o_out_en, 4'b0000);
    check("rst_busy", o_busy, 0);
    check("rst_switch_done", o_switch_done, 0);
    check("rst_invalid_req", o_invalid_req, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_out_en", o_out_en, 4'b0000);

    // 1: off -> tri; drain is exactly T+1..T+4, tri applied at T+5.
    do_req(3'b100, 0, 3'b100, 4'b0001, 5, t);
    for (int i = 1; i <= 4; i++) begin
      check("t1_drain_out_en", o_out_en, 4'b0000);
      check("t1_drain_busy", o_busy, 1);
      check("t1_drain_ready", o_req_ready, 0);
      @(negedge clk);
    end
    check("t1_applied_out_en", o_out_en, 4'b0001);
    wait_idle();

    // 3: same mode -> immediate switch_done; illegal code -> invalid_req, mode unchanged.
    do_req(3'b100, 0, 3'b100, 4'b0001, 1, t);
    check("t3_no_drain", o_busy, 0);
    do_req(3'b111, 1, 3'b100, 4'b0001, 1, t);
    do_req(3'b011, 1, 3'b100, 4'b0001, 1, t);
    wait_idle();

    // 2: tri -> saw, with r2r held during the drain and taken at the first STEADY cycle.
    do_req(3'b001, 0, 3'b001, 4'b1000, 5, t);
    i_req_valid = 1'b1;
    i_req_mode  = 3'b010;
    push(0, 3'b010, 4'b0010, t + 10);
    b = 0;
    while (!o_req_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("t2_held_accept_cyc", cyc, t + 5);
    @(negedge clk);
    i_req_valid = 1'b0;
    wait_idle();

    // Back to off, then 4: auto-scan from off through the full cycle.
    do_req(3'b000, 0, 3'b000, 4'b0000, 5, t);
    wait_idle();
    k = cyc;
    i_auto_en = 1'b1;
    push(0, 3'b100, 4'b0001, k + 20);
    push(0, 3'b010, 4'b0010, k + 40);
    push(0, 3'b110, 4'b0100, k + 60);
    push(0, 3'b001, 4'b1000, k + 80);
    push(0, 3'b100, 4'b0001, k + 100);

    // 5: buzz request lands on the dwell-expiry cycle in tri; request wins, dwell restarts.
    s = k + 100;
    wait_cyc(s + 15);
    check("t5_ready", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_mode  = 3'b110;
    push(0, 3'b110, 4'b0100, s + 20);
    push(0, 3'b001, 4'b1000, s + 40);
    @(negedge clk);
    i_req_valid = 1'b0;
    wait_cyc(s + 45);
    i_auto_en = 1'b0;
    wait_cyc(s + 90);
    check("auto_off_out_en", o_out_en, 4'b1000);
    check("auto_off_sb", sb.size(), 0);

    // 6: reset two cycles into a drain to saw.
    do_req(3'b100, 0, 3'b100, 4'b0001, 5, t);
    wait_idle();
    do_req(3'b001, 0, 3'b000, 4'b0000, 0, t);
    @(negedge clk);
    check("t6_in_drain", o_busy, 1);
    #1 reset = 1'b1;
    #1;
    check("t6_async_mode_sel", o_mode_sel, 3'b000);
    check("t6_async_out_en", o_out_en, 4'b0000);
    check("t6_async_busy", o_busy, 0);
    check("t6_async_ready", o_req_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_after_mode_sel", o_mode_sel, 3'b000);
    check("t6_after_out_en", o_out_en, 4'b0000);
    check("t6_after_busy", o_busy, 0);

    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
